// File: rtl/sim_mon_pkg.sv
// Shared types for the end-of-test monitor: FSM state and result encodings.
package sim_mon_pkg;

  localparam int unsigned RES_W    = 3;
  localparam int unsigned SETTLE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [RES_W-1:0] {
    RES_NONE    = 3'd0,
    RES_PASS    = 3'd1,
    RES_FAIL    = 3'd2,
    RES_TIMEOUT = 3'd3,
    RES_SWEND   = 3'd4
  } result_e;

endpackage

// File: rtl/sim_mon_ch.sv
// Per-channel slice: sticky done latch plus pass/code presentation for the settle sample.
module sim_mon_ch
  import sim_mon_pkg::*;
#(
  parameter int unsigned CODE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lat_clr,
  input  logic              lat_set,
  input  logic              ch_done,
  input  logic              ch_pass,
  input  logic [CODE_W-1:0] ch_code,
  output logic              done_lat,
  output logic              done_nxt_c,
  output logic              pass_c,
  output logic [CODE_W-1:0] code_c
);

  logic done_lat_d, done_lat_q;

  always_comb begin
    done_lat_d = done_lat_q;
    if (lat_clr) begin
      done_lat_d = 1'b0;
    end else if (lat_set && ch_done) begin
      done_lat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_lat_q <= 1'b0;
    end else begin
      done_lat_q <= done_lat_d;
    end
  end

  assign done_lat   = done_lat_q;
  assign done_nxt_c = done_lat_d;
  assign pass_c     = ch_pass;
  assign code_c     = ch_code;

endmodule

// File: rtl/sim_test_monitor.sv
// Multi-channel end-of-test monitor: run/settle/done FSM, timeout, software end,
// sticky pass/fail result with lowest-index failing channel.
module sim_test_monitor
  import sim_mon_pkg::*;
#(
  parameter int unsigned N_CH        = 1,
  parameter int unsigned CODE_W      = 32,
  parameter int unsigned SETTLE_CYC  = 3,
  parameter int unsigned TIMEOUT_CYC = 30000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sw_end,
  input  logic [N_CH-1:0]          ch_done,
  input  logic [N_CH-1:0]          ch_pass,
  input  logic [N_CH*CODE_W-1:0]   ch_code,
  output logic                     busy,
  output logic                     finished,
  output logic [RES_W-1:0]         result,
  output logic [$clog2(N_CH):0]    fail_ch,
  output logic [CODE_W-1:0]        fail_code,
  output logic [N_CH-1:0]          done_lat,
  output logic [CNT_W-1:0]         cycle_cnt
);

  localparam int unsigned FCH_W = $clog2(N_CH) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e                state_d, state_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [SETTLE_W-1:0]   settle_d, settle_q;
  result_e               result_d, result_q;
  logic [FCH_W-1:0]      fail_ch_d, fail_ch_q;
  logic [CODE_W-1:0]     fail_code_d, fail_code_q;
  logic                  busy_d, busy_q;
  logic                  finished_d, finished_q;

  logic                  lat_clr_c, lat_set_c;
  logic [N_CH-1:0]       done_nxt_c, pass_c;
  logic [N_CH-1:0][CODE_W-1:0] code_c;
  logic                  timeout_hit_c;
  logic                  any_fail_c;
  logic [FCH_W-1:0]      fail_idx_c;
  logic [CODE_W-1:0]     fail_sel_c;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    sim_mon_ch #(.CODE_W(CODE_W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .lat_clr    (lat_clr_c),
      .lat_set    (lat_set_c),
      .ch_done    (ch_done[g]),
      .ch_pass    (ch_pass[g]),
      .ch_code    (ch_code[g*CODE_W +: CODE_W]),
      .done_lat   (done_lat[g]),
      .done_nxt_c (done_nxt_c[g]),
      .pass_c     (pass_c[g]),
      .code_c     (code_c[g])
    );
  end

  // Lowest-index failing channel wins.
  always_comb begin
    any_fail_c = 1'b0;
    fail_idx_c = '0;
    fail_sel_c = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!pass_c[i] && !any_fail_c) begin
        any_fail_c = 1'b1;
        fail_idx_c = FCH_W'(i);
        fail_sel_c = code_c[i];
      end
    end
  end

  assign timeout_hit_c = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    result_d    = result_q;
    fail_ch_d   = fail_ch_q;
    fail_code_d = fail_code_q;
    lat_clr_c   = 1'b0;
    lat_set_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = RUN;
          cnt_d     = '0;
          settle_d  = '0;
          lat_clr_c = 1'b1;
        end
      end
      RUN, SETTLE: begin
        if (!en) begin
          state_d     = IDLE;
          result_d    = RES_NONE;
          fail_ch_d   = '0;
          fail_code_d = '0;
          lat_clr_c   = 1'b1;
        end else begin
          // Every non-aborted busy cycle counts, including the one that ends the run.
          cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          lat_set_c = (state_q == RUN);
          if (sw_end) begin
            state_d     = DONE;
            result_d    = RES_SWEND;
            fail_ch_d   = '0;
            fail_code_d = '0;
          end else if (timeout_hit_c) begin
            state_d     = DONE;
            result_d    = RES_TIMEOUT;
            fail_ch_d   = '0;
            fail_code_d = '0;
          end else if (state_q == SETTLE) begin
            if (settle_q == '0) begin
              state_d     = DONE;
              result_d    = any_fail_c ? RES_FAIL : RES_PASS;
              fail_ch_d   = fail_idx_c;
              fail_code_d = fail_sel_c;
            end else begin
              settle_d = settle_q - SETTLE_W'(1);
            end
          end else if (&done_nxt_c) begin
            state_d  = SETTLE;
            settle_d = SETTLE_W'(SETTLE_CYC);
          end
        end
      end
      DONE: begin
        if (clr) begin
          state_d     = IDLE;
          result_d    = RES_NONE;
          fail_ch_d   = '0;
          fail_code_d = '0;
          lat_clr_c   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d == RUN) || (state_d == SETTLE);
    finished_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      settle_q    <= '0;
      result_q    <= RES_NONE;
      fail_ch_q   <= '0;
      fail_code_q <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      result_q    <= result_d;
      fail_ch_q   <= fail_ch_d;
      fail_code_q <= fail_code_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  assign busy      = busy_q;
  assign finished  = finished_q;
  assign result    = result_q;
  assign fail_ch   = fail_ch_q;
  assign fail_code = fail_code_q;
  assign cycle_cnt = cnt_q;

endmodule
